// File: rtl/csi2tx_pixel_gen.sv
// Synthetic pixel source: frame_valid/line_valid/pixel_data frames with programmable timing.
// Optional build macro CSI2TX_PIXGEN_PRBS_EN swaps the counting pattern for PRBS-31 data.
module csi2tx_pixel_gen #(
  parameter int PIX_W_MAX = 24,
  parameter int FV_SETUP  = 4,
  parameter int FV_HOLD   = 4
) (
  input  logic                 ci_clk,
  input  logic                 ahb_hrst_n,
  input  logic                 clk_generated,
  input  logic                 start,
  input  logic                 stop,
  input  logic [31:0]          pixel_width,
  input  logic [15:0]          cfg_h_active,
  input  logic [15:0]          cfg_v_active,
  input  logic [15:0]          cfg_h_blank,
  input  logic [15:0]          cfg_v_blank,
  input  logic [7:0]           cfg_num_frames,
  output logic                 frame_valid,
  output logic                 line_valid,
  output logic [PIX_W_MAX-1:0] pixel_data,
  output logic [7:0]           frame_cnt,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state
);

  // Handshake: start is a one-cycle pulse honoured only in IDLE with clk_generated=1;
  // stop is a level that is made sticky and acted on at the next line end, FE exit or VBLANK.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FS     = 3'd1,
    S_LINE   = 3'd2,
    S_HBLANK = 3'd3,
    S_FE     = 3'd4,
    S_VBLANK = 3'd5
  } state_t;

  localparam logic [15:0] FS_LAST = 16'(FV_SETUP - 1);
  localparam logic [15:0] FE_LAST = 16'(FV_HOLD - 1);
  localparam logic [15:0] FE_EXIT = 16'(FV_HOLD);

  state_t               state;
  logic [15:0]          cnt;
  logic [15:0]          pix_cnt;
  logic [15:0]          line_cnt;
  logic                 stop_req;
  logic [15:0]          h_act_q;
  logic [15:0]          v_act_q;
  logic [15:0]          h_blk_q;
  logic [15:0]          v_blk_q;
  logic [7:0]           num_q;
  logic [PIX_W_MAX-1:0] mask_q;
  logic                 stop_now;

  logic                 load_en;
  logic [15:0]          load_line;
  logic [15:0]          load_pix;

  assign stop_now  = stop | stop_req;
  assign dbg_state = state;

  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  function automatic logic [PIX_W_MAX-1:0] width_mask(input logic [31:0] pw);
    logic [31:0] w;
    w = pw;
    if (w < 32'd6)
      w = 32'd6;
    else if (w > 32'(PIX_W_MAX))
      w = 32'(PIX_W_MAX);
    return PIX_W_MAX'((64'd1 << w) - 64'd1);
  endfunction

  always_ff @(posedge ci_clk or negedge ahb_hrst_n) begin
    if (!ahb_hrst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      stop_req    <= 1'b0;
      h_act_q     <= '0;
      v_act_q     <= '0;
      h_blk_q     <= '0;
      v_blk_q     <= '0;
      num_q       <= '0;
      mask_q      <= '0;
      frame_valid <= 1'b0;
      line_valid  <= 1'b0;
      frame_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE)
        stop_req <= stop_req | stop;
      case (state)
        S_IDLE: begin
          if (start && clk_generated) begin
            h_act_q     <= at_least_one(cfg_h_active);
            v_act_q     <= at_least_one(cfg_v_active);
            h_blk_q     <= at_least_one(cfg_h_blank);
            v_blk_q     <= cfg_v_blank;
            num_q       <= cfg_num_frames;
            mask_q      <= width_mask(pixel_width);
            frame_cnt   <= '0;
            stop_req    <= 1'b0;
            cnt         <= '0;
            frame_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= S_FS;
          end
        end
        S_FS: begin
          line_cnt <= '0;
          if (cnt == FS_LAST) begin
            cnt        <= '0;
            pix_cnt    <= '0;
            line_valid <= 1'b1;
            state      <= S_LINE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_LINE: begin
          if (pix_cnt == h_act_q - 16'd1) begin
            line_valid <= 1'b0;
            cnt        <= '0;
            if (stop_now || (line_cnt == v_act_q - 16'd1))
              state <= S_FE;
            else
              state <= S_HBLANK;
          end else begin
            pix_cnt <= pix_cnt + 16'd1;
          end
        end
        S_HBLANK: begin
          if (cnt == h_blk_q - 16'd1) begin
            cnt        <= '0;
            pix_cnt    <= '0;
            line_cnt   <= line_cnt + 16'd1;
            line_valid <= 1'b1;
            state      <= S_LINE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_FE: begin
          // FV_HOLD cycles with frame_valid high, then one exit cycle with it low.
          if (cnt == FE_LAST) begin
            frame_valid <= 1'b0;
            frame_cnt   <= frame_cnt + 8'd1;
            cnt         <= cnt + 16'd1;
          end else if (cnt == FE_EXIT) begin
            cnt <= '0;
            if (stop_now || ((num_q != 8'd0) && (frame_cnt == num_q))) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else if (v_blk_q == 16'd0) begin
              frame_valid <= 1'b1;
              state       <= S_FS;
            end else begin
              state <= S_VBLANK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_VBLANK: begin
          if (stop_now) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (cnt == v_blk_q - 16'd1) begin
            cnt         <= '0;
            frame_valid <= 1'b1;
            state       <= S_FS;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // load_en marks an edge after which line_valid is high; it selects the pixel shown next.
  always_comb begin
    load_en   = 1'b0;
    load_line = line_cnt;
    load_pix  = pix_cnt;
    case (state)
      S_FS: begin
        if (cnt == FS_LAST) begin
          load_en   = 1'b1;
          load_line = '0;
          load_pix  = '0;
        end
      end
      S_LINE: begin
        if (pix_cnt != h_act_q - 16'd1) begin
          load_en  = 1'b1;
          load_pix = pix_cnt + 16'd1;
        end
      end
      S_HBLANK: begin
        if (cnt == h_blk_q - 16'd1) begin
          load_en   = 1'b1;
          load_line = line_cnt + 16'd1;
          load_pix  = '0;
        end
      end
      default: ;
    endcase
  end

`ifdef CSI2TX_PIXGEN_PRBS_EN
  localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

  logic [30:0] lfsr_q;
  logic [30:0] lfsr_cur;

  // The seed is used directly on the FS->LINE edge so FV_SETUP=1 still starts from it.
  assign lfsr_cur = (state == S_FS) ? PRBS_SEED : lfsr_q;

  always_ff @(posedge ci_clk or negedge ahb_hrst_n) begin
    if (!ahb_hrst_n) begin
      lfsr_q     <= PRBS_SEED;
      pixel_data <= '0;
    end else begin
      if (load_en) begin
        pixel_data <= PIX_W_MAX'(64'(lfsr_cur)) & mask_q;
        lfsr_q     <= {lfsr_cur[29:0], lfsr_cur[30] ^ lfsr_cur[27]};
      end else begin
        pixel_data <= '0;
        if (state == S_FS)
          lfsr_q <= PRBS_SEED;
      end
    end
  end
`else
  logic [31:0] pat_sum;

  assign pat_sum = {16'd0, load_line} + {16'd0, load_pix};

  always_ff @(posedge ci_clk or negedge ahb_hrst_n) begin
    if (!ahb_hrst_n)
      pixel_data <= '0;
    else if (load_en)
      pixel_data <= PIX_W_MAX'(64'(pat_sum)) & mask_q;
    else
      pixel_data <= '0;
  end
`endif

endmodule

// File: tb/tb_csi2tx_pixel_gen.sv
// Bench for csi2tx_pixel_gen: directed and random frame sequences compared cycle by cycle
// against a frame-level model built from the timing rules.
module tb_csi2tx_pixel_gen;

  logic        ci_clk = 1'b0;
  logic        ahb_hrst_n = 1'b0;
  logic        clk_generated = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] pixel_width = '0;
  logic [15:0] cfg_h_active = '0;
  logic [15:0] cfg_v_active = '0;
  logic [15:0] cfg_h_blank = '0;
  logic [15:0] cfg_v_blank = '0;
  logic [7:0]  cfg_num_frames = '0;
  logic        frame_valid;
  logic        line_valid;
  logic [23:0] pixel_data;
  logic [7:0]  frame_cnt;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int fv_seen;
  int done_seen;

  // Per-cycle expectation: {frame_valid, line_valid, busy, done, frame_cnt, pixel_data}
  logic [35:0] exp_q[$];

  csi2tx_pixel_gen dut (
    .ci_clk         (ci_clk),
    .ahb_hrst_n     (ahb_hrst_n),
    .clk_generated  (clk_generated),
    .start          (start),
    .stop           (stop),
    .pixel_width    (pixel_width),
    .cfg_h_active   (cfg_h_active),
    .cfg_v_active   (cfg_v_active),
    .cfg_h_blank    (cfg_h_blank),
    .cfg_v_blank    (cfg_v_blank),
    .cfg_num_frames (cfg_num_frames),
    .frame_valid    (frame_valid),
    .line_valid     (line_valid),
    .pixel_data     (pixel_data),
    .frame_cnt      (frame_cnt),
    .busy           (busy),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  always #5 ci_clk = ~ci_clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [35:0] observed();
    return {frame_valid, line_valid, busy, done, frame_cnt, pixel_data};
  endfunction

  task automatic check_vec(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%09h expected=%09h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] width_mask(input int w);
    int cw;
    cw = (w < 6) ? 6 : ((w > 24) ? 24 : w);
    return 24'((64'd1 << cw) - 64'd1);
  endfunction

  function automatic logic [30:0] prbs31_next(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  // Builds the whole expected trace for one start, from the cycle after the start edge
  // through the done cycle. stop_cyc < 0 means stop is never raised.
  task automatic build_model(input int h, input int v, input int hb, input int vb,
                             input int nf, input int w, input int stop_cyc);
    int          hh, vv, hbb, c;
    bit          fin;
    bit          stop_hit;
    logic [7:0]  fc;
    logic [23:0] m, pix;
    logic [30:0] lf;
    hh  = (h == 0) ? 1 : h;
    vv  = (v == 0) ? 1 : v;
    hbb = (hb == 0) ? 1 : hb;
    m   = width_mask(w);
    fc  = 8'd0;
    c   = 0;
    fin = 1'b0;
    exp_q.delete();
    while (!fin && c < 20000) begin
      lf = 31'h7FFF_FFFF;
      repeat (4) begin exp_q.push_back({4'b1010, fc, 24'h0}); c++; end
      for (int l = 0; l < vv; l++) begin
        for (int p = 0; p < hh; p++) begin
`ifdef CSI2TX_PIXGEN_PRBS_EN
          pix = 24'(lf) & m;
          lf  = prbs31_next(lf);
`else
          pix = 24'(l + p) & m;
`endif
          exp_q.push_back({4'b1110, fc, pix}); c++;
        end
        stop_hit = (stop_cyc >= 0) && (c - 1 >= stop_cyc);
        if (l == vv - 1 || stop_hit) break;
        repeat (hbb) begin exp_q.push_back({4'b1010, fc, 24'h0}); c++; end
      end
      repeat (4) begin exp_q.push_back({4'b1010, fc, 24'h0}); c++; end
      fc = fc + 8'd1;
      exp_q.push_back({4'b0010, fc, 24'h0}); c++;
      stop_hit = (stop_cyc >= 0) && (c - 1 >= stop_cyc);
      if (stop_hit || (nf != 0 && fc == 8'(nf))) begin
        exp_q.push_back({4'b0001, fc, 24'h0}); c++;
        fin = 1'b1;
      end else begin
        for (int j = 0; j < vb; j++) begin
          exp_q.push_back({4'b0010, fc, 24'h0}); c++;
          if ((stop_cyc >= 0) && (c - 1 >= stop_cyc)) begin
            exp_q.push_back({4'b0001, fc, 24'h0}); c++;
            fin = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  // Starts a sequence and checks every cycle. stop_cyc raises stop after that cycle,
  // poke_cyc re-pulses start with different cfg, rst_cyc asserts reset mid-cycle.
  task automatic run_seq(input string tag, input int h, input int v, input int hb, input int vb,
                         input int nf, input int w, input int stop_cyc, input int poke_cyc,
                         input int rst_cyc);
    logic [35:0] last;
    build_model(h, v, hb, vb, nf, w, stop_cyc);
    fv_seen   = 0;
    done_seen = 0;
    @(negedge ci_clk);
    cfg_h_active   = 16'(h);
    cfg_v_active   = 16'(v);
    cfg_h_blank    = 16'(hb);
    cfg_v_blank    = 16'(vb);
    cfg_num_frames = 8'(nf);
    pixel_width    = 32'(w);
    clk_generated  = 1'b1;
    start          = 1'b1;
    @(negedge ci_clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      check_vec($sformatf("%s_cyc%0d", tag, i), observed(), exp_q[i]);
      fv_seen   += int'(frame_valid);
      done_seen += int'(done);
      if (i == rst_cyc) begin
        #2 ahb_hrst_n = 1'b0;
        #1 check_vec({tag, "_async_reset"}, observed(), 36'h0);
        @(negedge ci_clk);
        ahb_hrst_n = 1'b1;
        stop = 1'b0;
        return;
      end
      if (i == stop_cyc) stop = 1'b1;
      if (i == poke_cyc) begin
        start          = 1'b1;
        cfg_h_active   = 16'd9;
        cfg_v_active   = 16'd9;
        cfg_h_blank    = 16'd9;
        cfg_v_blank    = 16'd9;
        cfg_num_frames = 8'd0;
        pixel_width    = 32'd12;
      end else begin
        start = 1'b0;
      end
      @(negedge ci_clk);
    end
    stop = 1'b0;
    last = exp_q[exp_q.size() - 1];
    check_vec({tag, "_idle_after"}, observed(), {4'b0000, last[31:24], 24'h0});
  endtask

  initial begin
    int h, v, hb, vb, nf, w, sc;

    // Reset state
    repeat (2) @(negedge ci_clk);
    check_vec("reset_outputs", observed(), 36'h0);
    check_int("reset_state", int'(dbg_state), 0);
    ahb_hrst_n = 1'b1;
    @(negedge ci_clk);

    // start ignored while clocks are not generated
    clk_generated = 1'b0;
    cfg_h_active = 16'd4; cfg_v_active = 16'd2; cfg_num_frames = 8'd1; pixel_width = 32'd8;
    start = 1'b1;
    @(negedge ci_clk);
    start = 1'b0;
    repeat (3) begin
      check_vec("gated_start", observed(), 36'h0);
      @(negedge ci_clk);
    end

    // Single frame: 0,1,2,3 / 1,2,3,4 and an 18-cycle frame_valid envelope
    run_seq("single", 4, 2, 2, 0, 1, 8, -1, -1, -1);
    check_int("single_fv_cycles", fv_seen, 18);
    check_int("single_done_pulses", done_seen, 1);
    check_int("single_frame_cnt", int'(frame_cnt), 1);

    // Width clamping and pattern wrap
    run_seq("clamp_w40", 3, 1, 1, 0, 1, 40, -1, -1, -1);
    run_seq("clamp_w2_wrap", 70, 1, 1, 0, 1, 2, -1, -1, -1);
    run_seq("w8_nowrap", 70, 1, 1, 0, 1, 8, -1, -1, -1);

    // Zero substitution: two 1x1 frames, no VBLANK
    run_seq("zero_cfg", 0, 0, 0, 0, 2, 0, -1, -1, -1);
    check_int("zero_done_pulses", done_seen, 1);

    // start while busy (during frame 2) with altered cfg: no restart, frame_cnt kept
    run_seq("restart_ignored", 4, 2, 2, 3, 2, 8, -1, 23, -1);
    check_int("restart_frame_cnt", int'(frame_cnt), 2);

    // stop during line 2 pixel 1 of a free-running stream
    run_seq("stop_line2", 4, 8, 2, 0, 0, 8, 17, -1, -1);
    check_int("stop_frame_cnt", int'(frame_cnt), 1);
    check_int("stop_done_pulses", done_seen, 1);

    // stop held during VBLANK ends without another frame
    run_seq("stop_vblank", 2, 1, 1, 5, 0, 8, 12, -1, -1);

    // Reset mid-line, then a clean single frame
    run_seq("reset_mid", 4, 2, 2, 0, 1, 8, -1, -1, 5);
    check_int("reset_mid_state", int'(dbg_state), 0);
    run_seq("after_reset", 4, 2, 2, 0, 1, 8, -1, -1, -1);
    check_int("after_reset_fv_cycles", fv_seen, 18);

    // Two short frames: PRBS build re-seeds each frame
    run_seq("prbs_frames", 2, 1, 1, 0, 2, 8, -1, -1, -1);

    // Randomized configurations
    for (int r = 0; r < 8; r++) begin
      h  = $urandom_range(0, 6);
      v  = $urandom_range(0, 4);
      hb = $urandom_range(0, 3);
      vb = $urandom_range(0, 3);
      w  = $urandom_range(0, 40);
      nf = $urandom_range(0, 3);
      sc = (nf == 0) ? $urandom_range(0, 80) : -1;
      run_seq($sformatf("rand%0d", r), h, v, hb, vb, nf, w, sc, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
